m_gate_sweeper: RTL and testbench
=================================

# m_gate_sweeper

Self-checking stimulus/capture stage wrapped around the two-input logic-gate block. It drives the gate block's two operand bits through all four input combinations, waits a programmable settle time, samples the seven gate outputs and compares them against internally computed golden values. It sits directly upstream, as the feeder of `i_bit1`/`i_bit2`, and directly downstream, as the consumer of the seven gate outputs. It reports a per-gate failure mask and a pass flag.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range 1..15.
- `i_clk` in 1: sole clock, rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_start` in 1: start a sweep. Sampled only in IDLE.
- `i_abort` in 1: cancel a sweep in progress.
- `i_gate` in 7: gate outputs; bit 0 AND, 1 NAND, 2 OR, 3 NOR, 4 NOT, 5 XOR, 6 XNOR.
- `o_bit1` out 1: operand A to the gate block.
- `o_bit2` out 1: operand B to the gate block.
- `o_vec_idx` out 2: current vector index.
- `o_busy` out 1: sweep in progress.
- `o_done` out 1: one-cycle pulse when a sweep completes.
- `o_pass` out 1: last completed sweep had no mismatch.
- `o_fail_mask` out 7: per-gate sticky mismatch, same bit order as `i_gate`.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - `o_busy`=0.
  - `i_start`=1 → DRIVE; `o_vec_idx`←0, `o_fail_mask`←0, `o_pass`←0, settle counter←0.
- DRIVE:
  - `o_bit1`=`o_vec_idx[1]`, `o_bit2`=`o_vec_idx[0]`, both registered.
  - The counter increments each cycle.
  - When the counter reaches SETTLE_CYCLES-1 → SAMPLE.
- SAMPLE (one cycle):
  - `o_fail_mask` |= `i_gate` XOR golden(`o_bit1`,`o_bit2`).
  - If `o_vec_idx`==3 → DONE. Otherwise `o_vec_idx`+1 → DRIVE with counter←0.
- DONE (one cycle):
  - `o_done`=1, `o_pass`←(`o_fail_mask`==0), including the final SAMPLE's contribution.
  - → IDLE.
- Golden model: AND a&b, NAND ~(a&b), OR a|b, NOR ~(a|b), NOT ~a (b ignored), XOR a^b, XNOR ~(a^b).
- In IDLE, `o_fail_mask`, `o_pass`, `o_vec_idx`, `o_bit1` and `o_bit2` hold their last values until the next start.
- `o_busy`=1 in DRIVE, SAMPLE and DONE.
- `i_start` while busy is ignored.
- `i_abort`=1 in DRIVE or SAMPLE:
  - → IDLE next cycle.
  - No `o_done` pulse; `o_pass` stays 0.
  - `o_fail_mask` keeps its partial value.
  - `i_abort` has priority over the SAMPLE update, so that cycle's compare is discarded.
- `i_abort` in IDLE or DONE has no effect; DONE always completes.
- `i_start` and `i_abort` both high in IDLE: start wins.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0. All outputs 0: `o_bit1`, `o_bit2`, `o_vec_idx`, `o_busy`, `o_done`, `o_pass`, `o_fail_mask`.
- Reset mid-sweep aborts immediately and returns every output to these values.
- Start accepted at edge E0.
  - Vector 0 appears on `o_bit1`/`o_bit2` after E0.
  - Each vector lasts SETTLE_CYCLES+1 cycles.
  - `o_done` is high in the cycle after edge E0+4·(SETTLE_CYCLES+1).
  - Default SETTLE_CYCLES=2: `o_done` after edge E0+12; total sweep 13 cycles including DONE.
- The earliest next start is accepted in the first IDLE cycle after DONE.
- `o_bit1`/`o_bit2` are stable for the entire DRIVE+SAMPLE window of each vector.
- `i_gate` is sampled only at the SAMPLE edge. The gate block is purely combinational, so a settle time of 1 suffices.

## Structure
- Shared package `p_gate_sweep`:
  - gate bit-index constants: GATE_AND=0 … GATE_XNOR=6, NUM_GATES=7;
  - state enum;
  - NUM_VECTORS=4.
- Sub-module `m_gate_golden`: purely combinational; (a,b) → 7-bit expected vector in package bit order. It is reused by the bench scoreboard.
- The gate block itself is not instantiated inside the sweeper; the two are wired side by side at the next level up.

## Test plan
- Golden DUT: gate block wired back, SETTLE_CYCLES=2, start pulse.
  - Required: vectors 00, 01, 10, 11, each held 3 cycles; `o_done` after edge E0+12.
  - Required: `o_pass`=1, `o_fail_mask`=7'h00.
- Faulty XOR (`i_gate[5]` forced 0).
  - Required: mismatch at vectors 01 and 10; `o_fail_mask`=7'h20, `o_pass`=0.
- NOT wired to ~b instead of ~a.
  - Required: mismatch at 01 and 10; `o_fail_mask`=7'h10.
- `i_abort` during vector 2 DRIVE.
  - Required: IDLE next cycle, no `o_done` pulse, `o_pass`=0.
  - Follow-up: a restart performs a full clean sweep with mask cleared.
- `i_start` held high through the whole sweep.
  - Required: exactly one `o_done`, then a new sweep begins on the first IDLE cycle.
- `i_rst_n` asserted asynchronously at vector 1.
  - Required: all outputs 0 immediately.
  - Required: after release, no activity until a new `i_start`.

Source files
------------

// File: rtl/m_gate_sweeper_pkg.sv
// Shared definitions for the gate sweeper and its golden model.
//   - Gate bit positions in the 7-bit gate vector (AND..XNOR).
//   - Sweeper state encoding.
//   - Number of operand combinations swept.
package p_gate_sweep;

  localparam int GATE_AND    = 0;
  localparam int GATE_NAND   = 1;
  localparam int GATE_OR     = 2;
  localparam int GATE_NOR    = 3;
  localparam int GATE_NOT    = 4;
  localparam int GATE_XOR    = 5;
  localparam int GATE_XNOR   = 6;
  localparam int NUM_GATES   = 7;
  localparam int NUM_VECTORS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/m_gate_golden.sv
// Combinational reference model of the two-input gate block.
// Ports:
//   a_i      - operand A
//   b_i      - operand B (ignored by the NOT gate)
//   golden_o - expected gate outputs, bit order from p_gate_sweep
module m_gate_golden
  import p_gate_sweep::*;
(
  input  logic                 a_i,
  input  logic                 b_i,
  output logic [NUM_GATES-1:0] golden_o
);

  always_comb begin
    golden_o            = '0;
    golden_o[GATE_AND]  = a_i & b_i;
    golden_o[GATE_NAND] = ~(a_i & b_i);
    golden_o[GATE_OR]   = a_i | b_i;
    golden_o[GATE_NOR]  = ~(a_i | b_i);
    golden_o[GATE_NOT]  = ~a_i;
    golden_o[GATE_XOR]  = a_i ^ b_i;
    golden_o[GATE_XNOR] = ~(a_i ^ b_i);
  end

endmodule

// File: rtl/m_gate_sweeper.sv
// Stimulus/capture stage for the two-input gate block. Walks the operand
// pair through 00,01,10,11, holds each for SETTLE_CYCLES cycles, samples the
// seven gate outputs and accumulates a sticky per-gate mismatch mask.
// Ports:
//   i_clk, i_rst_n - clock (rising edge), async active-low reset
//   i_start        - begin a sweep (only looked at in IDLE)
//   i_abort        - cancel a sweep in DRIVE/SAMPLE
//   i_gate         - gate block outputs (AND,NAND,OR,NOR,NOT,XOR,XNOR)
//   o_bit1/o_bit2  - operands A/B driven to the gate block
//   o_vec_idx      - current vector index
//   o_busy/o_done  - sweep in progress / one-cycle completion pulse
//   o_pass         - last completed sweep was clean
//   o_fail_mask    - sticky per-gate mismatch
module m_gate_sweeper
  import p_gate_sweep::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [NUM_GATES-1:0] i_gate,
  output logic                 o_bit1,
  output logic                 o_bit2,
  output logic [1:0]           o_vec_idx,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [NUM_GATES-1:0] o_fail_mask
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [1:0] LAST_VEC    = 2'(NUM_VECTORS - 1);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [1:0]           vec_q, vec_d;
  logic                 bit1_q, bit1_d;
  logic                 bit2_q, bit2_d;
  logic [NUM_GATES-1:0] mask_q, mask_d;
  logic                 pass_q, pass_d;
  logic [NUM_GATES-1:0] golden;
  logic [1:0]           vec_inc;

  // Golden values come from the registered operands, i.e. exactly what the
  // gate block is seeing during this vector's window.
  m_gate_golden u_golden (
    .a_i      (bit1_q),
    .b_i      (bit2_q),
    .golden_o (golden)
  );

  assign vec_inc = vec_q + 2'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    bit1_d  = bit1_q;
    bit2_d  = bit2_q;
    mask_d  = mask_q;
    pass_d  = pass_q;

    unique case (state_q)
      ST_IDLE: begin
        // Start beats a simultaneous abort simply because abort is not
        // examined here.
        if (i_start) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
          vec_d   = '0;
          bit1_d  = 1'b0;
          bit2_d  = 1'b0;
          mask_d  = '0;
          pass_d  = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == SETTLE_LAST) begin
            state_d = ST_SAMPLE;
          end
        end
      end
      ST_SAMPLE: begin
        // Abort discards this cycle's compare.
        if (i_abort) begin
          state_d = ST_IDLE;
        end else begin
          mask_d = mask_q | (i_gate ^ golden);
          if (vec_q == LAST_VEC) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
            vec_d   = vec_inc;
            bit1_d  = vec_inc[1];
            bit2_d  = vec_inc[0];
          end
        end
      end
      ST_DONE: begin
        pass_d  = (mask_q == '0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      bit1_q  <= 1'b0;
      bit2_q  <= 1'b0;
      mask_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      bit1_q  <= bit1_d;
      bit2_q  <= bit2_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
    end
  end

  assign o_bit1      = bit1_q;
  assign o_bit2      = bit2_q;
  assign o_vec_idx   = vec_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DONE);
  assign o_pass      = pass_q;
  assign o_fail_mask = mask_q;

endmodule

// File: tb/tb_m_gate_sweeper.sv
module tb_m_gate_sweeper;
  import p_gate_sweep::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [6:0] gate;
  logic       bit1, bit2, busy, done, pass;
  logic [1:0] vec_idx;
  logic [6:0] fail_mask;
  logic [6:0] good;
  int         mode = 0;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  m_gate_sweeper #(.SETTLE_CYCLES(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_abort     (abort),
    .i_gate      (gate),
    .o_bit1      (bit1),
    .o_bit2      (bit2),
    .o_vec_idx   (vec_idx),
    .o_busy      (busy),
    .o_done      (done),
    .o_pass      (pass),
    .o_fail_mask (fail_mask)
  );

  // Healthy gate block, wired back from the sweeper's operands.
  m_gate_golden u_gate (.a_i(bit1), .b_i(bit2), .golden_o(good));

  // Fault injection on top of the healthy gate block.
  always_comb begin
    gate = good;
    case (mode)
      1: gate[5] = 1'b0;             // XOR stuck at 0
      2: gate[4] = ~bit2;            // NOT wired to ~b
      3: gate[0] = 1'b1;             // AND stuck at 1
      4: gate[3] = 1'b0;             // NOR stuck at 0
      5: gate    = ~good;            // every gate inverted
      default: gate = good;
    endcase
  end

  typedef struct {
    int         fault;
    logic [6:0] exp_mask;
    logic       exp_pass;
    string      name;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; returns right after the accepting edge (k=0).
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Full sweep: checks per-cycle operands, done timing, final mask and pass.
  task automatic run_sweep(input int fault, input logic [6:0] exp_mask,
                           input logic exp_pass, input string name);
    int  done_k;
    int  seq_ok;
    mode   = fault;
    seq_ok = 1;
    done_k = -1;
    pulse_start();
    for (int k = 0; k < 40; k++) begin
      if (k < 12) begin
        if ({bit1, bit2} != 2'(k / 3) || vec_idx != 2'(k / 3) || !busy || done)
          seq_ok = 0;
      end
      if (done) begin
        done_k = k;
        break;
      end
      tick();
    end
    check({name, " done_cycle"}, done_k, 12);
    check({name, " vector_seq"}, seq_ok, 1);
    tick();
    check({name, " idle_after"}, {busy, done}, 0);
    check({name, " fail_mask"}, int'(fail_mask), int'(exp_mask));
    check({name, " pass"}, int'(pass), int'(exp_pass));
  endtask

  initial begin
    int ndone;
    int idle_ok;

    vecs[0] = '{0, 7'h00, 1'b1, "golden"};
    vecs[1] = '{1, 7'h20, 1'b0, "xor_stuck0"};
    vecs[2] = '{2, 7'h10, 1'b0, "not_from_b"};
    vecs[3] = '{3, 7'h01, 1'b0, "and_stuck1"};
    vecs[4] = '{4, 7'h08, 1'b0, "nor_stuck0"};
    vecs[5] = '{5, 7'h7F, 1'b0, "all_inverted"};

    // Reset state
    #2;
    check("reset_outputs", {bit1, bit2, vec_idx, busy, done, pass, fail_mask}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", {busy, done}, 0);

    for (int i = 0; i < 6; i++) begin
      run_sweep(vecs[i].fault, vecs[i].exp_mask, vecs[i].exp_pass, vecs[i].name);
      tick();
    end

    // Abort during vector 2 DRIVE (k=6): partial mask keeps vector-1 XOR miss.
    mode = 1;
    pulse_start();
    repeat (6) tick();
    check("abort_pre_vec", int'(vec_idx), 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", int'(busy), 0);
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (done || busy) ndone++;
      tick();
    end
    check("abort_no_done", ndone, 0);
    check("abort_pass", int'(pass), 0);
    check("abort_partial_mask", int'(fail_mask), 'h20);
    check("abort_vec_hold", int'(vec_idx), 2);
    run_sweep(0, 7'h00, 1'b1, "restart_clean");
    tick();

    // Abort in vector 1 SAMPLE (k=5): that compare is discarded.
    mode = 1;
    pulse_start();
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_sample_mask", int'(fail_mask), 0);
    tick();

    // Start and abort together in IDLE: start wins.
    mode  = 0;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_beats_abort", int'(busy), 1);
    repeat (14) tick();
    check("sab_completed_pass", int'(pass), 1);

    // Start held high through the whole sweep.
    mode  = 0;
    start = 1'b1;
    tick();
    ndone = 0;
    for (int k = 0; k < 14; k++) begin
      if (done) ndone++;
      if (k == 13) check("held_idle_gap", int'(busy), 0);
      tick();
    end
    check("held_one_done", ndone, 1);
    check("held_restart", {busy, bit1, bit2}, 3'b100);
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // Asynchronous reset during vector 1.
    mode = 1;
    pulse_start();
    repeat (4) tick();
    check("rst_pre_vec", int'(vec_idx), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", {bit1, bit2, vec_idx, busy, done, pass, fail_mask}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_ok = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (busy || done || bit1 || bit2 || vec_idx != 2'd0) idle_ok = 0;
    end
    check("rst_stays_idle", idle_ok, 1);
    run_sweep(0, 7'h00, 1'b1, "post_rst_sweep");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
